// File: rtl/bcd_stopwatch_ctrl.sv
// bcd_stopwatch_ctrl: prescaled 4-digit BCD stopwatch with start/stop/clear/lap.
// Ports: clk, rst (async, high); start/stop/clear/lap levels; count, disp, running, lap_active, ovf.
module bcd_stopwatch_ctrl #(
  parameter int unsigned TICK_DIV = 4,
  parameter bit          WRAP     = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
  input  logic        clear,
  input  logic        lap,
  output logic [15:0] count,
  output logic [15:0] disp,
  output logic        running,
  output logic        lap_active,
  output logic        ovf
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSE,
    DONE
  } state_t;

  localparam logic [15:0] TMAX = 16'(TICK_DIV - 1);

  state_t      state, state_nx;
  logic [15:0] presc, presc_nx;
  logic [15:0] count_nx;
  logic [15:0] lap_reg, lap_reg_nx;
  logic        lap_active_nx;
  logic        ovf_nx;
  logic        adv;
  logic        tick;
  logic        at_max;
  logic        can_lap;

  // Ripple-carry step of the four decade digits.
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        cy;
    logic [3:0]  d;
    r  = v;
    cy = 1'b1;
    for (int k = 0; k < 4; k++) begin
      d = v[4*k +: 4];
      if (cy) begin
        if (d == 4'd9) begin
          d = 4'd0;
        end else begin
          d  = d + 4'd1;
          cy = 1'b0;
        end
      end
      r[4*k +: 4] = d;
    end
    return r;
  endfunction

  // A stop sampled in RUN freezes the prescaler on that same edge.
  assign adv     = (state == RUN) && !stop;
  assign tick    = adv && (presc == TMAX);
  assign at_max  = (count == 16'h9999);
  assign can_lap = (state == RUN) || (state == PAUSE);

  always_comb begin
    state_nx      = state;
    presc_nx      = presc;
    count_nx      = count;
    lap_reg_nx    = lap_reg;
    lap_active_nx = lap_active;
    ovf_nx        = 1'b0;
    if (clear) begin
      state_nx      = IDLE;
      presc_nx      = '0;
      count_nx      = '0;
      lap_reg_nx    = '0;
      lap_active_nx = 1'b0;
    end else begin
      if (can_lap && lap) begin
        if (lap_active) begin
          lap_active_nx = 1'b0;
        end else begin
          lap_reg_nx    = count;
          lap_active_nx = 1'b1;
        end
      end
      if (adv) begin
        presc_nx = tick ? 16'd0 : presc + 16'd1;
      end
      if (tick) begin
        if (at_max) begin
          ovf_nx = 1'b1;
          if (WRAP) begin
            count_nx = '0;
          end else begin
            state_nx = DONE;
          end
        end else begin
          count_nx = bcd_inc(count);
        end
      end
      unique case (state)
        IDLE, PAUSE: begin
          if (start && !stop) begin
            state_nx = RUN;
          end
        end
        RUN: begin
          if (stop) begin
            state_nx = PAUSE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      presc      <= '0;
      count      <= '0;
      lap_reg    <= '0;
      lap_active <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      state      <= state_nx;
      presc      <= presc_nx;
      count      <= count_nx;
      lap_reg    <= lap_reg_nx;
      lap_active <= lap_active_nx;
      ovf        <= ovf_nx;
    end
  end

  assign running = (state == RUN);
  assign disp    = lap_active ? lap_reg : count;

endmodule

// File: doc/bcd_stopwatch_ctrl.md
# bcd_stopwatch_ctrl

Sequencing controller for a 4-digit chain of decade (0–9) counters, forming a stopwatch. It divides the system clock into count ticks, steps the BCD digit chain with ripple carry, and handles start/stop/clear/lap commands through a small state machine. It drives the 7-segment display path with either the live or the frozen lap value, and flags overflow past 9999.

## Interface
- TICK_DIV, 4: clock cycles per count tick while running; legal range 1..65535.
- WRAP, 1: 1 = wrap 9999→0000 and keep running; 0 = saturate at 9999 and stop.

- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  level, sampled per cycle; enter RUN.
- stop  in  1  level, sampled per cycle; enter PAUSE.
- clear  in  1  level, sampled per cycle; return to IDLE with zero count.
- lap  in  1  level, sampled per cycle; toggle lap freeze.
- count  out  16  live BCD value; [3:0] = units digit, [15:12] = thousands.
- disp  out  16  displayed BCD value: lap_reg when lap_active, else count; combinational from registers.
- running  out  1  high in RUN.
- lap_active  out  1  high while the display is frozen on a lap.
- ovf  out  1  one-cycle pulse on a 9999 tick.

## Operation
- States:
  - IDLE: count 0000.
  - RUN.
  - PAUSE.
  - DONE: reached only when WRAP=0.
- Command priority: clear > stop > start. Lap is evaluated in the same cycle unless clear is high.
- Transitions:
  - clear, any state → IDLE. Zeroes count, prescaler and lap_reg; drops lap_active.
  - stop, RUN → PAUSE. Ignored in other states.
  - start, IDLE or PAUSE → RUN. Ignored in RUN and DONE.
  - start and stop high together: stop wins. RUN → PAUSE; IDLE stays IDLE; PAUSE stays PAUSE.
  - WRAP=0 and a tick at 9999 → DONE. Count holds 9999; only clear exits.
- Prescaler:
  - 16-bit; increments only in RUN; holds its value in PAUSE.
  - When it equals TICK_DIV−1 a tick fires and the prescaler returns to 0.
- Digit chain, on each tick:
  - Digit 0 increments.
  - Digit k increments only when digits 0..k−1 all equal 9.
  - A digit at 9 that increments becomes 0.
  - Digits never hold values 10–15.
- Tick at 9999:
  - WRAP=1: count → 0000, state stays RUN.
  - WRAP=0: count stays 9999, state → DONE.
  - Both cases raise ovf.
- Lap (RUN or PAUSE only; ignored in IDLE and DONE):
  - lap with lap_active=0: lap_reg ← count as it was before this edge; lap_active ← 1.
  - lap with lap_active=1: lap_active ← 0.
  - Count continues underneath the freeze.
- Reset values: state IDLE, prescaler 0, count 0000, lap_reg 0000, disp 0000, running 0, lap_active 0, ovf 0.
- Reset mid-run: immediate asynchronous return to all reset values. Count is not retained.

## Timing
- Start sampled at edge n: running=1 after edge n. The prescaler does not advance on edge n. The first tick is at edge n+TICK_DIV, so count=0001 after that edge.
- Steady RUN: count advances every TICK_DIV cycles. With TICK_DIV=1 it advances every cycle.
- Stop at edge m: running=0 after edge m, with no tick on edge m. Resume via start continues from the retained prescaler value.
- ovf is registered: high for exactly the one cycle following the edge that processed the 9999 tick.
- clear and a tick on the same edge: clear wins, so count=0000 and ovf=0.
- Lap capture: disp shows the captured value from the cycle after the lap edge.
- Commands are level-sampled. A command held N cycles acts every cycle; lap therefore toggles each cycle, so upstream supplies one-cycle pulses.

## Test plan
- Count-up: reset, TICK_DIV=4, start for 1 cycle → count=0001 after 4 RUN cycles; 0010 after 40; 0100 after 400.
- Pause/resume: stop 2 cycles after a tick (prescaler=1) → count frozen 20 cycles, running=0; start → next tick after 3 RUN cycles.
- Wrap: preload via run to 9999 with TICK_DIV=1, WRAP=1 → next edge count=0000, ovf=1 for exactly 1 cycle, running stays 1. With WRAP=0 → count holds 9999, running=0, start ignored, clear → 0000.
- Lap:
  - Lap at count=0037 → disp=0037 while count reaches 0050.
  - Lap again → disp=count.
  - Lap in IDLE → lap_active stays 0.
- Priority and reset:
  - start+stop in RUN → PAUSE.
  - clear+start in PAUSE → IDLE, count=0000.
  - rst asserted asynchronously mid-RUN between edges → all outputs zero immediately; after release, stays IDLE until start.
